axi4l_selftest_master: RTL

Synthesisable, parametrised AXI4-Lite master that writes a generated data pattern to a contiguous window of slave registers, reads the window back, and compares each beat against the regenerated pattern. It is the on-chip counterpart of the write-then-readback register check we run on the SHA3 peripheral in simulation. It sits in the block design next to the peripheral's S00_AXI port, behind an interconnect, so register integrity can be checked in hardware without a processor. It adds a selectable pattern generator, a configurable window, response checking and a saturating error count.

---
 rtl/axi4l_selftest_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi4l_selftest_master.sv
// axi4l_selftest_master
//   AXI4-Lite master that writes a generated pattern to a window of
//   C_NUM_WORDS slave registers, reads the window back and compares every
//   beat against the regenerated pattern. Only one transaction is
//   outstanding at a time.
// Ports
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   start, mode        start pulse (accepted in IDLE/DONE), pattern select
//                      (0 = increment, 1 = LFSR), mode latched on start
//   busy, done, pass   status; pass = done && err_count == 0
//   err_count          saturating count of failed beats
//   first_err_addr     address of the first failing beat, 0 if none
//   M_AXI_*            AXI4-Lite master channels AW, W, B, AR, R
module axi4l_selftest_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_WORDS        = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] C_SEED =
    {{(C_M_AXI_DATA_WIDTH-1){1'b0}}, 1'b1},
  parameter int C_ERR_WIDTH        = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            mode,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [C_ERR_WIDTH-1:0]          err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int BYTES = DW / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t          state, state_nxt;
  logic            aw_pend, w_pend;   // request still waiting for its READY
  logic [8:0]      idx;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   pat, pat_nxt;
  logic            mode_q, fb;
  logic            accept, b_hs, r_hs, last, err_ev;

  // XNOR feedback keeps the all-zero word from being a fixed point.
  if (DW == 64) begin : g_fb64
    assign fb = ~(pat[63] ^ pat[62] ^ pat[60] ^ pat[59]);
  end else begin : g_fb32
    assign fb = ~(pat[31] ^ pat[21] ^ pat[1] ^ pat[0]);
  end

  assign pat_nxt = mode_q ? {pat[DW-2:0], fb} : pat + DW'(1);
  assign last    = (idx == 9'(C_NUM_WORDS - 1));
  assign accept  = start && (state == IDLE || state == DONE);
  assign b_hs    = (state == WR_RESP) && M_AXI_BVALID;
  assign r_hs    = (state == RD_RESP) && M_AXI_RVALID;
  // A read beat with both a bad response and bad data is still one event.
  assign err_ev  = (b_hs && M_AXI_BRESP != 2'b00) ||
                   (r_hs && (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != pat));

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_WDATA   = pat;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = aw_pend;
  assign M_AXI_WVALID  = w_pend;
  assign pass          = done && (err_count == '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = WR_REQ;
      WR_REQ: begin
        busy = 1'b1;
        // Each channel is complete once it was seen, or is seen now.
        if ((!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY))
          state_nxt = WR_RESP;
      end
      WR_RESP: begin
        busy = 1'b1;
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = last ? RD_REQ : WR_REQ;
      end
      RD_REQ: begin
        busy = 1'b1;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        busy = 1'b1;
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_nxt = last ? DONE : RD_REQ;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = WR_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_pend        <= 1'b0;
      w_pend         <= 1'b0;
      idx            <= '0;
      addr           <= '0;
      pat            <= '0;
      mode_q         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (accept) begin
      aw_pend        <= 1'b1;
      w_pend         <= 1'b1;
      idx            <= '0;
      addr           <= C_BASE_ADDR;
      pat            <= C_SEED;
      mode_q         <= mode;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (state == WR_REQ) begin
        if (M_AXI_AWREADY) aw_pend <= 1'b0;
        if (M_AXI_WREADY)  w_pend  <= 1'b0;
      end
      if (b_hs || r_hs) begin
        if (last) begin
          // Rewind so the read phase regenerates the sequence from the seed.
          idx  <= '0;
          addr <= C_BASE_ADDR;
          pat  <= C_SEED;
        end else begin
          idx  <= idx + 9'd1;
          addr <= addr + AW'(BYTES);
          pat  <= pat_nxt;
        end
      end
      if (b_hs && !last) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end
      if (err_ev) begin
        if (err_count != '1) err_count <= err_count + C_ERR_WIDTH'(1);
        // The counter saturates, so zero means no earlier event this run.
        if (err_count == '0) first_err_addr <= addr;
      end
    end
  end

endmodule
